vga_dac_regs: RTL and testbench
===============================

# vga_dac_regs

Palette DAC register block for the VGA path. It holds the 256-entry × 18-bit colour look-up table, programmed by the CPU through the standard DAC ports (3C6h–3C9h). It converts each pixel index from the attribute stage into an 18-bit bgr triple. That triple feeds the CGA-port quantiser, which reduces it to 4-bit IRGB.

## Interface
Parameters:
- none; table depth is fixed at 256 and component width at 6.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- io_addr  in  2  register select: 0=3C6 mask, 1=3C7 read index / state, 2=3C8 write index, 3=3C9 data.
- io_write  in  1  one-cycle write strobe; exactly one side effect per asserted cycle.
- io_read  in  1  one-cycle read strobe; exactly one side effect per asserted cycle.
- io_din  in  8  CPU write data; for 3C9 only bits [5:0] are used.
- io_dout  out  8  registered CPU read data.
- pix_index  in  8  pixel palette index, one per clk.
- bgr  out  18  registered colour: [17:12]=B, [11:6]=G, [5:0]=R.

## Operation
- **State:**
  - palette[256] of 18 bits; not reset.
  - stage_r and stage_g, 6 bits each.
  - wr_idx and rd_idx, 8 bits each.
  - comp: 2-bit counter over R=0, G=1, B=2; value 3 is never reached.
  - mode: WRITE or READ.
  - mask: 8 bits.
- **Reset values:** wr_idx=0, rd_idx=0, comp=0, mode=WRITE, mask=FFh, stage_r=0, stage_g=0, io_dout=00h, bgr=0.
- **Write 3C6:** mask <= io_din.
- **Write 3C7:** rd_idx <= io_din, comp <= 0, mode <= READ.
- **Write 3C8:** wr_idx <= io_din, comp <= 0, mode <= WRITE.
- **Write 3C9:**
  - comp=0: stage_r <= io_din[5:0], comp <= 1.
  - comp=1: stage_g <= io_din[5:0], comp <= 2.
  - comp=2: palette[wr_idx] <= {io_din[5:0], stage_g, stage_r}, wr_idx <= wr_idx+1 (255 wraps to 0), comp <= 0.
  - The write is accepted in either mode.
- **Read 3C9:** io_dout <= {2'b00, component comp of palette[rd_idx]}.
  - comp advances 0→1→2.
  - On comp=2: rd_idx <= rd_idx+1 (wraps), comp <= 0.
- **Read 3C6:** returns mask.
- **Read 3C7:** returns 03h in READ mode, 00h in WRITE mode.
- **Read 3C8:** returns wr_idx.
- **No strobe:** io_dout holds its last value.
- **Shared counter:** comp is shared by reads and writes. Mixing 3C9 reads and writes without reloading an index continues the same component sequence.
- **Pixel path:** bgr <= palette[pix_index & mask] every cycle. The pixel path is independent of the CPU side.
- **Same-entry collision:** a pixel lookup in the same cycle as a palette write to that entry returns the old value; the new value is visible from the next cycle.
- **Simultaneous strobes:** io_write and io_read in the same cycle cannot occur. If they do, io_write wins and io_read is ignored.

## Timing
- CPU read latency: io_dout is valid in the cycle after the io_read strobe.
- Palette write: committed at the clock edge of the third 3C9 write; readable by a pixel lookup one cycle later.
- Pixel latency: exactly one clk from pix_index to bgr. Sustained throughput is one index per clk.
- Index or mask reload mid-triple: any partial triple is discarded and stage_r/stage_g are not committed.
- Reset mid-triple: the partial triple is discarded and the palette contents are unchanged.
- Implement the palette as dual-port RAM:
  - one synchronous read port for pixels;
  - one read/write port for the CPU.

## Test plan
- **Reset defaults:** assert reset, release, read 3C6, 3C7, 3C8 → FFh, 00h, 00h; bgr=0.
- **Program and lookup:** write 3C8=10h, then 3C9=3Fh,15h,2Ah → palette[10h]=2A_15_3F in B_G_R order. pix_index=10h → bgr=18'b101010_010101_111111 one cycle later. Read 3C8 → 11h.
- **Read-back with wrap:** write 3C8=FFh and load FFh with 01h,02h,03h, then load 00h with 04h,05h,06h. Write 3C7=FFh, then read 3C9 six times → 01h,02h,03h,04h,05h,06h. Read 3C7 → 03h.
- **Mask:** 3C6=0Fh, pix_index=F3h → bgr=palette[03h]. 3C6=FFh → bgr=palette[F3h].
- **Abort mid-triple:** write 3C8=20h, 3C9=11h,22h, then 3C8=20h and 3C9=01h,02h,03h → palette[20h]={03h,02h,01h}. Repeat with reset between the 2nd and 3rd writes → palette[20h] unchanged.
- **Same-entry collision:** pix_index held at 05h while the third 3C9 write commits entry 05h → old value in the collision cycle, new value on the following bgr.

Source files
------------

// File: rtl/vga_dac_regs_if.sv
// CPU-side DAC register bus (ports 3C6h-3C9h) shared by the palette block and its bus master.
interface vga_dac_regs_if;
    logic [1:0] io_addr;
    logic       io_write;
    logic       io_read;
    logic [7:0] io_din;
    logic [7:0] io_dout;

    modport master (
        output io_addr, io_write, io_read, io_din,
        input  io_dout
    );

    modport slave (
        input  io_addr, io_write, io_read, io_din,
        output io_dout
    );
endinterface

// File: rtl/vga_dac_regs.sv
// VGA palette DAC: 256 x 18-bit colour table programmed through 3C6h-3C9h, with a
// one-cycle pixel lookup port that runs independently of the CPU side.
module vga_dac_regs (
    input  logic                  clk,
    input  logic                  reset,
    vga_dac_regs_if.slave         bus,
    input  logic [7:0]            pix_index,
    output logic [17:0]           bgr
);
    typedef enum logic {MODE_WRITE = 1'b0, MODE_READ = 1'b1} mode_t;

    logic [17:0] palette [256];

    logic [5:0]  stage_r_reg, stage_r_next;
    logic [5:0]  stage_g_reg, stage_g_next;
    logic [7:0]  wr_idx_reg,  wr_idx_next;
    logic [7:0]  rd_idx_reg,  rd_idx_next;
    logic [7:0]  mask_reg,    mask_next;
    logic [1:0]  comp_reg,    comp_next;
    mode_t       mode_reg,    mode_next;
    logic [7:0]  dout_next;
    logic        pal_we;
    logic [17:0] pal_wdata;
    logic [17:0] rd_word;

    // CPU port read data feeds the component mux ahead of the io_dout register.
    assign rd_word   = palette[rd_idx_reg];
    assign pal_wdata = {bus.io_din[5:0], stage_g_reg, stage_r_reg};

    always_comb begin
        stage_r_next = stage_r_reg;
        stage_g_next = stage_g_reg;
        wr_idx_next  = wr_idx_reg;
        rd_idx_next  = rd_idx_reg;
        mask_next    = mask_reg;
        comp_next    = comp_reg;
        mode_next    = mode_reg;
        dout_next    = bus.io_dout;
        pal_we       = 1'b0;

        if (bus.io_write) begin
            case (bus.io_addr)
                2'd0: begin
                    // Reloading the mask also drops any half-entered triple.
                    mask_next = bus.io_din;
                    comp_next = 2'd0;
                end
                2'd1: begin
                    rd_idx_next = bus.io_din;
                    comp_next   = 2'd0;
                    mode_next   = MODE_READ;
                end
                2'd2: begin
                    wr_idx_next = bus.io_din;
                    comp_next   = 2'd0;
                    mode_next   = MODE_WRITE;
                end
                default: begin
                    case (comp_reg)
                        2'd0: begin
                            stage_r_next = bus.io_din[5:0];
                            comp_next    = 2'd1;
                        end
                        2'd1: begin
                            stage_g_next = bus.io_din[5:0];
                            comp_next    = 2'd2;
                        end
                        2'd2: begin
                            pal_we      = 1'b1;
                            wr_idx_next = wr_idx_reg + 8'd1;
                            comp_next   = 2'd0;
                        end
                        default: comp_next = 2'd0;
                    endcase
                end
            endcase
        end else if (bus.io_read) begin
            case (bus.io_addr)
                2'd0: dout_next = mask_reg;
                2'd1: dout_next = (mode_reg == MODE_READ) ? 8'h03 : 8'h00;
                2'd2: dout_next = wr_idx_reg;
                default: begin
                    case (comp_reg)
                        2'd0: begin
                            dout_next = {2'b00, rd_word[5:0]};
                            comp_next = 2'd1;
                        end
                        2'd1: begin
                            dout_next = {2'b00, rd_word[11:6]};
                            comp_next = 2'd2;
                        end
                        2'd2: begin
                            dout_next   = {2'b00, rd_word[17:12]};
                            rd_idx_next = rd_idx_reg + 8'd1;
                            comp_next   = 2'd0;
                        end
                        default: comp_next = 2'd0;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_r_reg <= 6'd0;
            stage_g_reg <= 6'd0;
            wr_idx_reg  <= 8'd0;
            rd_idx_reg  <= 8'd0;
            mask_reg    <= 8'hFF;
            comp_reg    <= 2'd0;
            mode_reg    <= MODE_WRITE;
            bus.io_dout <= 8'h00;
        end else begin
            stage_r_reg <= stage_r_next;
            stage_g_reg <= stage_g_next;
            wr_idx_reg  <= wr_idx_next;
            rd_idx_reg  <= rd_idx_next;
            mask_reg    <= mask_next;
            comp_reg    <= comp_next;
            mode_reg    <= mode_next;
            bus.io_dout <= dout_next;
        end
    end

    // Table contents survive reset; a commit coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (pal_we && !reset) begin
            palette[wr_idx_reg] <= pal_wdata;
        end
    end

    // Pixel port reads before the same-edge CPU write, so a collision returns the old entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            bgr <= 18'd0;
        end else begin
            bgr <= palette[pix_index & mask_reg];
        end
    end
endmodule

// File: tb/tb_vga_dac_regs.sv
// Directed bench for vga_dac_regs: stimulus pushes expectations into queues, a monitor pops and checks.
module tb_vga_dac_regs;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pix_index = 8'd0;
    logic [17:0] bgr;
    logic        pix_chk = 1'b0;
    logic        rd_seen = 1'b0;
    logic        pix_seen = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        string       name;
        logic [17:0] val;
    } exp_t;

    exp_t cpu_q[$];
    exp_t pix_q[$];

    vga_dac_regs_if bus();

    vga_dac_regs dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .pix_index (pix_index),
        .bgr       (bgr)
    );

    always #5 clk = ~clk;

    // Remember which cycles should produce an observable result.
    always @(posedge clk) begin
        rd_seen  <= bus.io_read && !bus.io_write;
        pix_seen <= pix_chk;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rd_seen) begin
            n_checks++;
            if (cpu_q.size() == 0) begin
                n_fail++;
                $display("FAIL cpu_read: got %02h but no expected value queued", bus.io_dout);
            end else begin
                e = cpu_q.pop_front();
                if (bus.io_dout !== e.val[7:0]) begin
                    n_fail++;
                    $display("FAIL %s: io_dout=%02h expected %02h", e.name, bus.io_dout, e.val[7:0]);
                end else begin
                    $display("ok   %s: io_dout=%02h", e.name, bus.io_dout);
                end
            end
        end
        if (pix_seen) begin
            n_checks++;
            if (pix_q.size() == 0) begin
                n_fail++;
                $display("FAIL pixel: got %05h but no expected value queued", bgr);
            end else begin
                e = pix_q.pop_front();
                if (bgr !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: bgr=%05h expected %05h", e.name, bgr, e.val);
                end else begin
                    $display("ok   %s: bgr=%05h", e.name, bgr);
                end
            end
        end
    end

    // All tasks start and end on a falling edge.
    task automatic cpu_wr(input logic [1:0] addr, input logic [7:0] data);
        bus.io_addr  = addr;
        bus.io_din   = data;
        bus.io_write = 1'b1;
        @(negedge clk);
        bus.io_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [1:0] addr, input logic [7:0] exp_val, input string name);
        exp_t e;
        e.name = name;
        e.val  = {10'd0, exp_val};
        cpu_q.push_back(e);
        bus.io_addr = addr;
        bus.io_read = 1'b1;
        @(negedge clk);
        bus.io_read = 1'b0;
    endtask

    task automatic pix_check(input logic [7:0] idx, input logic [17:0] exp_val, input string name);
        exp_t e;
        e.name = name;
        e.val  = exp_val;
        pix_q.push_back(e);
        pix_index = idx;
        pix_chk   = 1'b1;
        @(negedge clk);
        pix_chk = 1'b0;
    endtask

    task automatic load_entry(input logic [7:0] idx, input logic [5:0] r, input logic [5:0] g,
                              input logic [5:0] b);
        cpu_wr(2'd2, idx);
        cpu_wr(2'd3, {2'b00, r});
        cpu_wr(2'd3, {2'b00, g});
        cpu_wr(2'd3, {2'b00, b});
    endtask

    initial begin
        exp_t e;
        bus.io_addr  = 2'd0;
        bus.io_din   = 8'h00;
        bus.io_write = 1'b0;
        bus.io_read  = 1'b0;
        repeat (3) @(negedge clk);

        // Outputs held at zero while reset is asserted.
        pix_check(8'h00, 18'd0, "bgr_in_reset");
        cpu_rd(2'd0, 8'h00, "dout_in_reset");
        reset = 1'b0;

        cpu_rd(2'd0, 8'hFF, "rst_mask");
        cpu_rd(2'd1, 8'h00, "rst_state");
        cpu_rd(2'd2, 8'h00, "rst_wr_idx");

        // Program entry 10h and look it up.
        load_entry(8'h10, 6'h3F, 6'h15, 6'h2A);
        pix_check(8'h10, 18'b101010_010101_111111, "lookup_10");
        cpu_rd(2'd2, 8'h11, "wr_idx_after_10");

        // Write across the FFh -> 00h wrap, then read back through the same wrap.
        cpu_wr(2'd2, 8'hFF);
        for (int i = 1; i <= 6; i++) cpu_wr(2'd3, 8'(i));
        cpu_rd(2'd2, 8'h01, "wr_idx_wrapped");
        cpu_wr(2'd1, 8'hFF);
        cpu_rd(2'd3, 8'h01, "rb_ff_r");
        cpu_rd(2'd3, 8'h02, "rb_ff_g");
        cpu_rd(2'd3, 8'h03, "rb_ff_b");
        cpu_rd(2'd3, 8'h04, "rb_00_r");
        cpu_rd(2'd3, 8'h05, "rb_00_g");
        cpu_rd(2'd3, 8'h06, "rb_00_b");
        cpu_rd(2'd1, 8'h03, "state_read_mode");

        // Mask selects between entries 03h and F3h.
        load_entry(8'h03, 6'h07, 6'h08, 6'h09);
        load_entry(8'hF3, 6'h0A, 6'h0B, 6'h0C);
        cpu_wr(2'd0, 8'h0F);
        cpu_rd(2'd0, 8'h0F, "mask_0f");
        pix_check(8'hF3, {6'h09, 6'h08, 6'h07}, "masked_f3");
        cpu_wr(2'd0, 8'hFF);
        pix_check(8'hF3, {6'h0C, 6'h0B, 6'h0A}, "unmasked_f3");

        // Index reload mid-triple discards the partial entry.
        cpu_wr(2'd2, 8'h20);
        cpu_wr(2'd3, 8'h11);
        cpu_wr(2'd3, 8'h22);
        load_entry(8'h20, 6'h01, 6'h02, 6'h03);
        pix_check(8'h20, {6'h03, 6'h02, 6'h01}, "abort_reload_20");

        // Reset mid-triple: entry 20h unchanged, and the sequence restarts at R for index 00h.
        cpu_wr(2'd2, 8'h20);
        cpu_wr(2'd3, 8'h31);
        cpu_wr(2'd3, 8'h32);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cpu_wr(2'd3, 8'h33);
        pix_check(8'h20, {6'h03, 6'h02, 6'h01}, "abort_reset_20");
        cpu_wr(2'd3, 8'h34);
        cpu_wr(2'd3, 8'h35);
        pix_check(8'h00, {6'h35, 6'h34, 6'h33}, "after_reset_00");

        // Same-entry collision on 05h.
        load_entry(8'h05, 6'h0C, 6'h1B, 6'h2A);
        cpu_wr(2'd2, 8'h05);
        cpu_wr(2'd3, 8'h3E);
        cpu_wr(2'd3, 8'h3D);
        e.name = "collision_old";
        e.val  = {6'h2A, 6'h1B, 6'h0C};
        pix_q.push_back(e);
        pix_index    = 8'h05;
        pix_chk      = 1'b1;
        bus.io_addr  = 2'd3;
        bus.io_din   = 8'h3C;
        bus.io_write = 1'b1;
        @(negedge clk);
        bus.io_write = 1'b0;
        pix_chk      = 1'b0;
        pix_check(8'h05, {6'h3C, 6'h3D, 6'h3E}, "collision_new");

        // Drain: anything left unobserved is a failure.
        for (int i = 0; i < 8 && (cpu_q.size() != 0 || pix_q.size() != 0); i++) @(negedge clk);
        n_checks++;
        if (cpu_q.size() != 0 || pix_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d cpu and %0d pixel expectations left, required 0",
                     cpu_q.size(), pix_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end
endmodule
